// File: rtl/sti_pkg.sv
// Shared types for the serial receive path: length codes, frame config and FSM states.
package sti_pkg;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 6;

  typedef enum logic [1:0] {LEN_8 = 2'd0, LEN_16 = 2'd1, LEN_24 = 2'd2, LEN_32 = 2'd3} len_e;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  typedef struct packed {
    len_e len;
    logic msb;
  } rx_cfg_t;

  // Expected frame length in bits: 8*(code+1).
  function automatic logic [LEN_W-1:0] exp_bits(len_e len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction
endpackage

// File: rtl/sti_rx_fifo.sv
// DEPTH x W circular FIFO; head is exposed combinationally and reads as zero when empty.
module sti_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/sti_sipo_rx.sv
// Serial-to-parallel receiver: frames are contiguous so_valid runs, length-checked on the
// falling edge of so_valid and queued in a small FIFO for the host side.
module sti_sipo_rx
  import sti_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   so_valid,
  input  logic                   so_data,
  input  logic [1:0]             cfg_length,
  input  logic                   cfg_msb,
  input  logic                   rx_rd,
  output logic [WORD_W-1:0]      rx_data,
  output logic                   rx_empty,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   err_short,
  output logic                   err_long,
  output logic                   err_ovf
);
  state_e            state;
  rx_cfg_t           cfg_q;
  logic [WORD_W-1:0] word;
  logic [CNT_W-1:0]  cnt, exp_cnt;
  logic              commit, is_short, is_long, fifo_full, push, ovf;

  assign exp_cnt  = CNT_W'(exp_bits(cfg_q.len));
  assign commit   = (state == SHIFT) && !so_valid;
  assign is_short = cnt < exp_cnt;
  assign is_long  = cnt > exp_cnt;
  assign push     = commit && !is_short && (!fifo_full || rx_rd);
  assign ovf      = commit && !is_short && fifo_full && !rx_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cfg_q     <= '0;
      word      <= '0;
      cnt       <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_short <= commit && is_short;
      err_long  <= commit && is_long;
      err_ovf   <= ovf;
      case (state)
        IDLE: if (so_valid) begin
          state <= SHIFT;
          cfg_q <= '{len: len_e'(cfg_length), msb: cfg_msb};
          word  <= {{(WORD_W-1){1'b0}}, so_data};
          cnt   <= CNT_W'(1);
        end
        SHIFT: if (so_valid) begin
          // Bits past the expected length are counted but not stored.
          if (cnt < exp_cnt) begin
            if (cfg_q.msb) word <= {word[WORD_W-2:0], so_data};
            else           word[cnt[4:0]] <= so_data;
          end
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
        end else begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sti_rx_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (word),
    .pop   (rx_rd),
    .rdata (rx_data),
    .count (rx_count),
    .empty (rx_empty),
    .full  (fifo_full)
  );
endmodule

// File: doc/sti_sipo_rx.md
# sti_sipo_rx

Serial-to-parallel receiver sitting directly downstream of the serial transmitter stage. It samples `so_data` while `so_valid` is high, rebuilds each contiguous valid run (one frame) into a right-aligned 32-bit word using the same length/bit-order configuration the transmitter was given, and checks the frame length. Completed words go into a 4-entry FIFO read by the host-side checker.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `CNT_W`, 6: bit-counter width. Saturates at all-ones.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `so_valid`  in  1  serial bit qualifier from transmitter.
- `so_data`  in  1  serial bit, sampled when `so_valid`=1.
- `cfg_length`  in  2  frame size code: 0/1/2/3 → 8/16/24/32 bits.
- `cfg_msb`  in  1  1 = first bit received is the MSB; 0 = first bit is the LSB.
- `rx_rd`  in  1  pop FIFO head; ignored when `rx_empty`=1.
- `rx_data`  out  32  FIFO head word, right-aligned, upper bits zero.
- `rx_empty`  out  1  FIFO empty.
- `rx_count`  out  3  FIFO occupancy, 0..DEPTH.
- `err_short`  out  1  one-cycle pulse: frame shorter than expected, dropped.
- `err_long`  out  1  one-cycle pulse: frame longer than expected, truncated.
- `err_ovf`  out  1  one-cycle pulse: good frame dropped, FIFO full.

## Operation
- Two states:
  - IDLE: waiting for a frame.
  - SHIFT: collecting bits.
- IDLE → SHIFT on the first cycle with `so_valid`=1:
  - Latch `cfg_length` and `cfg_msb`.
  - Clear the shift register, then load bit 0.
  - Set count to 1.
  - Config changes mid-frame have no effect.
- Expected length: E = 8*(len+1), computed in 6 bits.
- In SHIFT, each cycle with `so_valid`=1 and count < E:
  - msb order: `word <= {word[30:0], so_data}`.
  - lsb order: `word[count] <= so_data`.
  - Then count increments.
- Bits arriving when count ≥ E are discarded. count still increments, saturating at 63.
- Frame end is the first SHIFT cycle with `so_valid`=0. In that cycle, return to IDLE and commit:
  - count < E: drop the word, pulse `err_short`.
  - count > E: treat the word as good, pulse `err_long`.
  - Good word and FIFO not full, or full with `rx_rd` in the same cycle: push the word.
  - Good word and FIFO full with no `rx_rd`: drop the word, pulse `err_ovf`. `err_long` may pulse in the same cycle.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Simultaneous push and pop leaves count unchanged.
  - A pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
- Reset in the middle of a frame aborts it with no error pulse. Bits that follow before `so_valid` drops start a new, short frame; `err_short` on that frame is correct behaviour.

## Timing
- Reset values:
  - `rx_data`=0, `rx_empty`=1, `rx_count`=0.
  - All `err_*`=0.
  - State IDLE, FIFO pointers 0.
- Input and error latency:
  - `so_data` is sampled on the same edge at which `so_valid` is seen high.
  - `err_*` are registered and assert the cycle after the commit cycle.
- Push latency:
  - Last valid bit at cycle t; `so_valid` low at t+1.
  - Push on the t+1 edge; `rx_empty` falls and `rx_data` is valid from cycle t+2.
- `rx_data` is combinational from the head entry. It is 0 when empty.
- A pop on cycle t exposes the next entry at t+1.
- Back-to-back frames need ≥1 cycle of `so_valid`=0 between them. A bit on the cycle right after the commit starts a new frame with no loss.

## Structure
- Shared package `sti_pkg`:
  - Length code encoding and the E table (8/16/24/32).
  - State enum {IDLE, SHIFT}.
  - Word width 32.
- One sub-module: `sti_rx_fifo`, a parameterised DEPTH × 32 synchronous FIFO with push/pop/count/empty/full. The top module holds the state machine, shift register and length checker.

## Test plan
- len=1, msb=1, send 16 bits of 0xA5C3 msb-first → `rx_data`=0x0000A5C3 from the second cycle after `so_valid` falls; no error pulse.
- len=3, msb=0, send 32 bits of 0x12345678 lsb-first → `rx_data`=0x12345678.
- len=0, only 5 bits sent → `err_short` pulses once, `rx_empty` stays 1.
- len=0, 10 bits sent, first 8 = 0x3C msb-first → `rx_data`=0x3C and `err_long` pulses.
- Five 8-bit frames (0x01..0x05), no reads:
  - `rx_count`=4 and `err_ovf` pulses on frame 5.
  - Then read 4 times → 0x01..0x04 in order, `rx_empty`=1.
- Reset low after 10 of 16 bits, released while `so_valid` is still high:
  - Outputs return to reset values immediately.
  - No error pulse during reset; the leftover bits give one `err_short`.
  - A following full 16-bit frame is received correctly.
